// File: rtl/rtx_cmd_rx.sv
// ---------------------------------------------------------------------------
// rtx_cmd_rx -- byte-stream command receiver with a small command FIFO.
//
// Bytes arrive one per in_strobe cycle (while ena is high) and are assembled
// into commands {op, arg0, arg1}:
//   * 0x00              : NOP, discarded
//   * bit7 = 1          : short command, committed at once with args 0x00
//   * otherwise         : opcode, followed by arg0 and arg1
// With RTX_CMD_CSUM_EN defined, 3-byte frames carry a 4th byte that must
// equal op^arg0^arg1. Without it, the CSUM state does not exist and
// err_flags[2] stays 0.
//
// Completed commands are written into a first-word-fall-through FIFO. The
// downstream core pops the head entry with cmd_ready. The pop side keeps
// running even while ena is low.
//
// Parameters:
//   DEPTH   -- FIFO entries (power of 2, 2..16)
//   TIMEOUT -- idle enabled cycles tolerated inside a frame (1..255)
//
// Ports:
//   clk, rst_n          -- clock (rising edge), async active-low reset
//   ena                 -- enables the byte/FSM side
//   in_data, in_strobe  -- incoming byte and its valid strobe
//   err_clr             -- clears the sticky error flags
//   cmd_ready           -- downstream accepts the head command
//   cmd_valid           -- FIFO non-empty
//   cmd_op/arg0/arg1    -- head command fields (0x00 when empty)
//   fifo_level          -- current entry count
//   err_flags           -- sticky {csum, timeout, overflow}
// ---------------------------------------------------------------------------
module rtx_cmd_rx #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [7:0]             in_data,
  input  logic                   in_strobe,
  input  logic                   err_clr,
  input  logic                   cmd_ready,
  output logic                   cmd_valid,
  output logic [7:0]             cmd_op,
  output logic [7:0]             cmd_arg0,
  output logic [7:0]             cmd_arg1,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [2:0]             err_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [7:0]    TO_LAST  = 8'(TIMEOUT - 1);

`ifdef RTX_CMD_CSUM_EN
  typedef enum logic [1:0] {IDLE, ARG0, ARG1, CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, ARG0, ARG1} state_t;
`endif

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  arg0_q, arg0_d;
`ifdef RTX_CMD_CSUM_EN
  logic [7:0]  arg1_q, arg1_d;
`endif

  logic        commit_req;
  logic [23:0] commit_data;
  logic        timeout_evt;
  logic        csum_evt;

  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, push, ovf_evt;

  // -------------------------------------------------------------------------
  // Frame FSM: state and frame registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      arg0_q  <= '0;
`ifdef RTX_CMD_CSUM_EN
      arg1_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      arg0_q  <= arg0_d;
`ifdef RTX_CMD_CSUM_EN
      arg1_q  <= arg1_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Frame FSM: next state, commit request, error events
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    arg0_d      = arg0_q;
`ifdef RTX_CMD_CSUM_EN
    arg1_d      = arg1_q;
`endif
    commit_req  = 1'b0;
    commit_data = '0;
    timeout_evt = 1'b0;
    csum_evt    = 1'b0;

    // ena low freezes state and the timeout counter entirely.
    if (ena) begin
      if (in_strobe) begin
        cnt_d = '0;
        case (state_q)
          IDLE: begin
            if (in_data[7]) begin
              commit_req  = 1'b1;
              commit_data = {in_data, 16'h0000};
            end else if (in_data != 8'h00) begin
              op_d    = in_data;
              state_d = ARG0;
            end
          end
          ARG0: begin
            arg0_d  = in_data;
            state_d = ARG1;
          end
          ARG1: begin
`ifdef RTX_CMD_CSUM_EN
            arg1_d  = in_data;
            state_d = CSUM;
`else
            commit_req  = 1'b1;
            commit_data = {op_q, arg0_q, in_data};
            state_d     = IDLE;
`endif
          end
`ifdef RTX_CMD_CSUM_EN
          CSUM: begin
            state_d = IDLE;
            if (in_data == (op_q ^ arg0_q ^ arg1_q)) begin
              commit_req  = 1'b1;
              commit_data = {op_q, arg0_q, arg1_q};
            end else begin
              csum_evt = 1'b1;
            end
          end
`endif
          default: state_d = IDLE;
        endcase
      end else if (state_q != IDLE) begin
        // Idle cycle inside a frame: the TIMEOUT-th one abandons the frame.
        if (cnt_q == TO_LAST) begin
          state_d     = IDLE;
          cnt_d       = '0;
          timeout_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Command FIFO
  // -------------------------------------------------------------------------
  assign cmd_valid = (fifo_level != '0);
  assign full      = (fifo_level == LVL_FULL);
  assign pop       = cmd_valid & cmd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push      = commit_req & (~full | pop);
  assign ovf_evt   = commit_req & full & ~pop;

  // NOTE: the storage array has no reset; emptiness is tracked by fifo_level
  // and the head outputs are gated with cmd_valid, so stale contents are
  // never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= commit_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      // Power-of-2 depth: pointers wrap naturally modulo DEPTH.
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_ONE;
        2'b01:   fifo_level <= fifo_level - LVL_ONE;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  assign {cmd_op, cmd_arg0, cmd_arg1} = cmd_valid ? mem[rd_ptr] : 24'h000000;

  // -------------------------------------------------------------------------
  // Sticky error flags: a new event wins over a simultaneous clear.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flags <= 3'b000;
    end else begin
      err_flags <= (err_clr ? 3'b000 : err_flags) | {csum_evt, timeout_evt, ovf_evt};
    end
  end

endmodule

// File: tb/tb_rtx_cmd_rx.sv
// ---------------------------------------------------------------------------
// tb_rtx_cmd_rx -- self-checking bench for rtx_cmd_rx.
// Reference model: a queue of expected commands, a queue holding the bytes of
// the frame in progress and an idle-cycle count; stepped once per clock edge
// and compared against every DUT output after each edge.
// Directed scenarios first, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_rtx_cmd_rx;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
`ifdef RTX_CMD_CSUM_EN
  localparam int FRAME_LEN = 4;
`else
  localparam int FRAME_LEN = 3;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   ena = 1'b0;
  logic [7:0]             in_data = 8'h00;
  logic                   in_strobe = 1'b0;
  logic                   err_clr = 1'b0;
  logic                   cmd_ready = 1'b0;
  logic                   cmd_valid;
  logic [7:0]             cmd_op, cmd_arg0, cmd_arg1;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [2:0]             err_flags;

  rtx_cmd_rx #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .in_data    (in_data),
    .in_strobe  (in_strobe),
    .err_clr    (err_clr),
    .cmd_ready  (cmd_ready),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_arg0   (cmd_arg0),
    .cmd_arg1   (cmd_arg1),
    .fifo_level (fifo_level),
    .err_flags  (err_flags)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [23:0] m_fifo[$];
  logic [7:0]  m_frame[$];
  int          m_idle;
  logic [2:0]  m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_frame.delete();
    m_idle = 0;
    m_err  = 3'b000;
  endtask

  // One clock edge of the specified behaviour, given that cycle's inputs.
  task automatic model_step(input logic e, input logic s, input logic [7:0] d,
                            input logic clr, input logic rdy);
    logic        pop, commit, ovf, tevt, cevt;
    logic [23:0] entry;
    pop    = (m_fifo.size() > 0) && rdy;
    commit = 1'b0;
    tevt   = 1'b0;
    cevt   = 1'b0;
    entry  = 24'h0;
    if (e && s) begin
      m_idle = 0;
      if (m_frame.size() == 0) begin
        if (d[7]) begin
          commit = 1'b1;
          entry  = {d, 16'h0000};
        end else if (d != 8'h00) begin
          m_frame.push_back(d);
        end
      end else begin
        m_frame.push_back(d);
        if (m_frame.size() == FRAME_LEN) begin
          entry = {m_frame[0], m_frame[1], m_frame[2]};
          if (FRAME_LEN == 4 && m_frame[FRAME_LEN-1] != (m_frame[0] ^ m_frame[1] ^ m_frame[2]))
            cevt = 1'b1;
          else
            commit = 1'b1;
          m_frame.delete();
        end
      end
    end else if (e && m_frame.size() > 0) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_frame.delete();
        m_idle = 0;
        tevt   = 1'b1;
      end
    end
    ovf = commit && (m_fifo.size() == DEPTH) && !pop;
    if (pop) void'(m_fifo.pop_front());
    if (commit && !ovf) m_fifo.push_back(entry);
    m_err = (clr ? 3'b000 : m_err) | {cevt, tevt, ovf};
  endtask

  task automatic compare_all(input string tag);
    logic [23:0] head;
    head = (m_fifo.size() > 0) ? m_fifo[0] : 24'h0;
    check({tag, "_valid"}, 32'(cmd_valid), 32'(m_fifo.size() > 0));
    check({tag, "_head"},  32'({cmd_op, cmd_arg0, cmd_arg1}), 32'(head));
    check({tag, "_level"}, 32'(fifo_level), 32'(m_fifo.size()));
    check({tag, "_err"},   32'(err_flags), 32'(m_err));
  endtask

  // Drive one cycle on the falling edge, step the model on the rising edge,
  // compare shortly after.
  task automatic cyc(input logic e, input logic s, input logic [7:0] d,
                     input logic clr, input logic rdy, input string tag);
    @(negedge clk);
    ena       = e;
    in_strobe = s;
    in_data   = d;
    err_clr   = clr;
    cmd_ready = rdy;
    @(posedge clk);
    model_step(e, s, d, clr, rdy);
    #1 compare_all(tag);
  endtask

  task automatic send(input logic [7:0] d, input string tag);
    cyc(1'b1, 1'b1, d, 1'b0, 1'b0, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, tag);
  endtask

  task automatic drain_and_clear(input string tag);
    for (int i = 0; i <= DEPTH; i++) cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, tag);
  endtask

  initial begin
    logic       r_e, r_s, r_clr, r_rdy;
    logic [7:0] r_d;
    int         cls, strobe_pct;

    // Reset state
    model_reset();
    #3;
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_head",  32'({cmd_op, cmd_arg0, cmd_arg1}), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_err",   32'(err_flags), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Full 3-byte frame, valid the cycle after the last byte
    send(8'h12, "f3_b0");
    send(8'h34, "f3_b1");
    check("f3_not_yet_valid", 32'(cmd_valid), 32'd0);
`ifdef RTX_CMD_CSUM_EN
    send(8'h56, "f3_b2");
    check("f3_wait_csum", 32'(cmd_valid), 32'd0);
    send(8'h70, "f3_b3");
`else
    send(8'h56, "f3_b2");
`endif
    check("f3_valid", 32'(cmd_valid), 32'd1);
    check("f3_fields", 32'({cmd_op, cmd_arg0, cmd_arg1}), 32'h123456);
    check("f3_level", 32'(fifo_level), 32'd1);
    drain_and_clear("f3_drain");

    // NOP then short command
    send(8'h00, "nop");
    check("nop_nothing", 32'(cmd_valid), 32'd0);
    send(8'h85, "short");
    check("short_fields", 32'({cmd_op, cmd_arg0, cmd_arg1}), 32'h850000);
    check("short_level", 32'(fifo_level), 32'd1);
    drain_and_clear("short_drain");

    // Overflow: five shorts into a 4-deep FIFO
    for (int i = 0; i < 5; i++) send(8'h81 + 8'(i), "ovf_fill");
    check("ovf_level", 32'(fifo_level), 32'd4);
    check("ovf_err", 32'(err_flags), 32'b001);
    // Commit and pop together while full
    cyc(1'b1, 1'b1, 8'h86, 1'b0, 1'b1, "full_pop_commit");
    check("fpc_level", 32'(fifo_level), 32'd4);
    check("fpc_head", 32'(cmd_op), 32'h82);
    check("fpc_err", 32'(err_flags), 32'b001);
    drain_and_clear("ovf_drain");
    check("clr_err", 32'(err_flags), 32'd0);
    // Pop when empty
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "pop_empty");
    check("pop_empty_level", 32'(fifo_level), 32'd0);

    // Timeout
    send(8'h10, "to_op");
    idle(TIMEOUT - 1, "to_wait");
    check("to_not_yet", 32'(err_flags[1]), 32'd0);
    idle(1, "to_fire");
    check("to_flag", 32'(err_flags[1]), 32'd1);
    send(8'h81, "to_short");
    check("to_short_fields", 32'({cmd_op, cmd_arg0, cmd_arg1}), 32'h810000);
    drain_and_clear("to_drain");

    // ena low freezes the frame and ignores strobes
    send(8'h10, "ena_op");
    for (int i = 0; i < 2 * TIMEOUT; i++) cyc(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, "ena_off");
    check("ena_no_timeout", 32'(err_flags), 32'd0);
    send(8'h20, "ena_a0");
    send(8'h30, "ena_a1");
`ifdef RTX_CMD_CSUM_EN
    send(8'h00, "ena_cs");
`endif
    check("ena_fields", 32'({cmd_op, cmd_arg0, cmd_arg1}), 32'h102030);
    // Pop side keeps working with ena low
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "ena_off_pop");
    check("ena_off_pop_level", 32'(fifo_level), 32'd0);
    drain_and_clear("ena_drain");

`ifdef RTX_CMD_CSUM_EN
    send(8'h12, "cs_bad0");
    send(8'h34, "cs_bad1");
    send(8'h56, "cs_bad2");
    send(8'h00, "cs_bad3");
    check("cs_bad_dropped", 32'(cmd_valid), 32'd0);
    check("cs_bad_flag", 32'(err_flags), 32'b100);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "cs_clr");
    check("cs_clr_flag", 32'(err_flags), 32'd0);
`endif

    // Reset mid-frame with a non-empty FIFO
    send(8'h81, "rm_pre");
    send(8'h12, "rm_b0");
    send(8'h34, "rm_b1");
    @(negedge clk);
    in_strobe = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rm_async_valid", 32'(cmd_valid), 32'd0);
    check("rm_async_head",  32'({cmd_op, cmd_arg0, cmd_arg1}), 32'd0);
    check("rm_async_level", 32'(fifo_level), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h56, "rm_post");
    idle(2, "rm_post_idle");
    check("rm_no_commit", 32'(cmd_valid), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      strobe_pct = ((i / 300) % 2 == 0) ? 50 : 8;
      r_e   = ($urandom_range(0, 9) != 0);
      r_s   = ($urandom_range(0, 99) < strobe_pct);
      cls   = $urandom_range(0, 7);
      r_d   = 8'($urandom_range(0, 127));
      if (cls == 0)      r_d = 8'h00;
      else if (cls < 3)  r_d = r_d | 8'h80;
      r_clr = ($urandom_range(0, 19) == 0);
      r_rdy = ($urandom_range(0, 9) < 3);
      cyc(r_e, r_s, r_d, r_clr, r_rdy, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rtx_cmd_rx.md
RTX_CMD_RX -- requirements
Module: rtx_cmd_rx

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, command FIFO depth in entries (power of 2, 2..16).
REQ-002 SHALL provide parameter TIMEOUT, default 255, idle cycles allowed between bytes of one frame (1..255).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ena  input  1  block enable; low gates the input side only.
REQ-006 SHALL have port in_data  input  8  command byte (driven from ui_in).
REQ-007 SHALL have port in_strobe  input  1  in_data valid this cycle, one byte per high cycle.
REQ-008 SHALL have port err_clr  input  1  clear all sticky error flags.
REQ-009 SHALL have port cmd_ready  input  1  downstream core accepts head command.
REQ-010 SHALL have port cmd_valid  output  1  FIFO non-empty.
REQ-011 SHALL have ports cmd_op, cmd_arg0, cmd_arg1  output  8 each  head command fields.
REQ-012 SHALL have port fifo_level  output  $clog2(DEPTH)+1  current entry count.
REQ-013 SHALL have port err_flags  output  3  sticky {csum, timeout, overflow}, bits [2:0].

Function
REQ-014 SHALL run FSM states IDLE, ARG0, ARG1, CSUM; byte accepted only when in_strobe=1 and ena=1.
REQ-015 In IDLE: opcode 0x00 (NOP) SHALL be discarded; opcode bit7=1 SHALL be a short command committed immediately with args 0x00; otherwise SHALL latch opcode and go to ARG0.
REQ-016 ARG0 SHALL latch arg0 -> ARG1; ARG1 SHALL latch arg1 and commit (-> IDLE), or -> CSUM when checksum enabled.
REQ-017 Commit SHALL write {op,arg0,arg1} on the edge of the final accepted byte; cmd_valid SHALL be high from the next cycle (1-cycle latency, first-word fall-through).
REQ-018 Pop SHALL occur on any edge with cmd_valid=1 and cmd_ready=1; outputs SHALL show next entry the following cycle.
REQ-019 Commit while full with no pop SHALL drop the frame and set err_flags[0]; commit and pop together when full SHALL both succeed, level unchanged.
REQ-020 Pop when empty SHALL have no effect; fifo_level SHALL never exceed DEPTH or underflow.
REQ-021 Timeout counter SHALL reset on every accepted byte, count each cycle with ena=1 in ARG0/ARG1/CSUM, and on reaching TIMEOUT SHALL abandon the frame, return to IDLE, set err_flags[1].
REQ-022 ena=0 SHALL freeze FSM and timeout counter and ignore in_strobe; pop side SHALL operate regardless of ena.
REQ-023 err_clr SHALL clear err_flags next edge; an error event in the same cycle SHALL win (flag stays set).
REQ-024 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-025 rst_n low SHALL immediately force: FSM IDLE, FIFO empty, fifo_level 0, cmd_valid 0, cmd_op/arg0/arg1 0x00, err_flags 0, timeout counter 0.
REQ-026 Reset mid-frame SHALL discard the partial frame; no commit after release until a full new frame.

Configuration
REQ-027 Macro RTX_CMD_CSUM_EN defined: 3-byte frames SHALL carry a 4th byte equal to op^arg0^arg1; mismatch SHALL drop frame and set err_flags[2]; short commands carry no checksum.
REQ-028 RTX_CMD_CSUM_EN undefined: CSUM state absent, commit on arg1, err_flags[2] tied 0.

Verification
REQ-029 Bytes 0x12,0x34,0x56 back-to-back, cmd_ready=0 -> cmd_valid=1 cycle after 0x56, op/arg0/arg1=0x12/0x34/0x56, fifo_level=1.
REQ-030 Bytes 0x00 then 0x85 -> single entry op=0x85 args 0x00; NOP produces nothing.
REQ-031 Five short commands 0x81..0x85, cmd_ready=0, DEPTH=4 -> level 4, 0x85 dropped, err_flags=3'b001; then pop with 5th commit in same cycle -> no new error.
REQ-032 Byte 0x10, then TIMEOUT idle cycles -> IDLE, err_flags[1]=1; following 0x81 commits as short command.
REQ-033 RTX_CMD_CSUM_EN: 0x12,0x34,0x56,0x70 -> committed; 0x12,0x34,0x56,0x00 -> dropped, err_flags[2]=1; err_clr -> 0.
REQ-034 rst_n low after 0x12,0x34 -> outputs zero asynchronously; after release 0x56 alone does not commit.
